ifu_pair_fetch: RTL and testbench
=================================

// Module: ifu_pair_fetch
// PURPOSE
//  Instruction fetch unit that feeds the dual-slot (p0/p1) front end and the branch unit.
//  - Holds the committed PC and issues one 32-bit pair read per advance to a req/ack instruction memory.
//  - Presents the pair as p0 (even word) / p1 (odd word).
//  - Pulses fetch_next_out to the branch unit, then loads the branch unit's pc_next_in.
//  - Sits between instruction memory and the branch unit / decode stage.
// PARAMETERS
//  RESET_PC  9'h000     PC loaded on reset; bit0 forced 0
//  NOP_IR    16'h0000   IR value driven on p0/p1 while no valid pair is held
// PORTS
//  clk            in   1   system clock, all state on posedge
//  rst            in   1   synchronous, active-high reset
//  stall_in       in   1   downstream hold; blocks advance while 1
//  pc_next_in     in   9   next PC from branch unit (sampled only when fetch_next_out=1)
//  pc_out         out  9   PC of pair currently presented (always even)
//  fetch_next_out out  1   1-cycle advance strobe to branch unit
//  p0_ir_out      out  16  instruction at pc_out
//  p1_ir_out      out  16  instruction at pc_out+1
//  ir_valid_out   out  1   p0/p1 hold a fetched pair
//  imem_req       out  1   memory request, held until imem_ack
//  imem_addr      out  8   pair index = pc[8:1], stable while imem_req=1
//  imem_ack       in   1   1-cycle completion; imem_rdata valid same cycle
//  imem_rdata     in   32  {p1 word [31:16], p0 word [15:0]}
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - pc_q=RESET_PC&~1; state=BOOT; ir_valid_out=0; p0/p1=NOP_IR; fetch_next_out=0; imem_req=0.
//   - Memory clears its own in-flight request on rst, so no stale ack is seen after reset.
//  States:
//   - BOOT: imem_req=0 for one cycle -> WAIT.
//   - WAIT: imem_req=1, imem_addr=pc_q[8:1]; ir_valid_out=0; p0/p1=NOP_IR.
//     - imem_ack=1 -> latch p0=rdata[15:0], p1=rdata[31:16]; ir_valid_out=1 next cycle; go VALID.
//     - No timeout; waits indefinitely.
//   - VALID: pair held stable; imem_req=0.
//     - fetch_next_out = ~stall_in (combinational).
//     - On fetch_next_out=1: pc_q<={pc_next_in[8:1],1'b0}; ir_valid_out=0 and p0/p1=NOP_IR next cycle; go WAIT.
//     - stall_in=1: stay VALID; pc/IR/valid unchanged (no re-fetch).
//  Latency: min 2 cycles from fetch_next_out to next ir_valid_out (ack one cycle after req); +1 per memory wait cycle.
//  Timing rules:
//   - At most one outstanding request.
//   - imem_ack outside WAIT is ignored.
//   - fetch_next_out is never 1 outside VALID.
//  Odd pc_next_in: bit0 dropped; p0 slot invalidation for odd targets is the branch unit's job.
//  Wrap: pc_next_in=9'h1FE wraps naturally; no special case.
//  Reset mid-WAIT or mid-stall: returns to BOOT; pending ack discarded; outputs take reset values.
// STRUCTURE
//  - Shared package kl_fetch_pkg:
//    - fetch_state_t enum {BOOT,WAIT,VALID}
//    - localparam NOP_IR_DEFAULT
//    - typedef ir_pair_t (struct p1,p0)
//  - State, pc_q, IR pair and valid built from existing vDFF / vDFF_en register cells.
//  - One natural sub-module: ifu_pair_latch, a 32-bit IR pair register with load and NOP-clear.
//  - Target 150-250 lines.
// TESTING
//  1. Reset, mem acks 1 cycle after req with 32'hBEEF_1234 at addr 0 -> p0=16'h1234, p1=16'hBEEF,
//     pc_out=0, valid=1 on 3rd cycle after reset release.
//  2. VALID, stall_in=1 for 5 cycles -> fetch_next_out=0, outputs frozen, imem_req=0; release ->
//     fetch_next_out=1 exactly one cycle.
//  3. Advance with pc_next_in=9'h023 -> imem_addr=8'h11, pc_out=9'h022, valid low until ack.
//  4. Memory delays ack 4 cycles -> imem_req/addr stable, valid=0, p0/p1=NOP_IR throughout, then pair latched.
//  5. rst asserted while WAIT with ack arriving same cycle -> ack ignored, BOOT, pc_out=RESET_PC, valid=0.
//  6. pc_next_in=9'h1FE then 9'h000 -> addr 8'hFF then 8'h00, no X, correct pairs.

Source files
------------

// File: rtl/kl_fetch_pkg.sv
// Shared fetch-unit types: FSM states, IR pair layout and the default NOP encoding.
package kl_fetch_pkg;

   // Fetch sequencer states; the unused encoding 2'b11 is steered back to BOOT.
   typedef enum logic [1:0] {
      BOOT  = 2'b00,
      WAIT  = 2'b01,
      VALID = 2'b10
   } fetch_state_t;

   // Instruction word shown on both slots while no fetched pair is held.
   localparam logic [15:0] NOP_IR_DEFAULT = 16'h0000;

   // Memory returns {p1, p0}; p0 is the even word, p1 the odd word.
   typedef struct packed {
      logic [15:0] p1;
      logic [15:0] p0;
   } ir_pair_t;

   // Pair with both slots set to the given NOP encoding.
   function automatic ir_pair_t nop_pair(input logic [15:0] nop);
      ir_pair_t pair;
      pair.p1 = nop;
      pair.p0 = nop;
      return pair;
   endfunction

endpackage

// File: rtl/ifu_pair_latch.sv
// 32-bit IR pair register: loads a fetched pair, or clears both slots to NOP.
module ifu_pair_latch
   import kl_fetch_pkg::*;
#(
   parameter logic [15:0] NOP_IR = NOP_IR_DEFAULT
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  logic     clr,
   input  ir_pair_t d,
   output ir_pair_t q
);

   localparam ir_pair_t NOP_PAIR = nop_pair(NOP_IR);

   ir_pair_t pair_nxt_s;
   logic     en_s;

   // Choose the next pair; clear beats load so an advance always blanks both slots.
   always_comb begin
      pair_nxt_s = q;
      en_s       = 1'b0;
      if (clr) begin
         pair_nxt_s = NOP_PAIR;
         en_s       = 1'b1;
      end else if (load) begin
         pair_nxt_s = d;
         en_s       = 1'b1;
      end else begin
         pair_nxt_s = q;
         en_s       = 1'b0;
      end
   end

   vDFF_en #(
      .WIDTH   (32),
      .RST_VAL (NOP_PAIR)
   ) u_pair_reg (
      .clk (clk),
      .rst (rst),
      .en  (en_s),
      .d   (pair_nxt_s),
      .q   (q)
   );

endmodule

// File: rtl/vDFF.sv
// Plain register cell with synchronous active-high reset to RST_VAL.
module vDFF #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d every cycle; reset has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/vDFF_en.sv
// Register cell with load enable and synchronous active-high reset to RST_VAL.
module vDFF_en #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Capture d only when enabled; reset has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/ifu_pair_fetch.sv
// Pair fetch unit: holds the committed PC, fetches one 32-bit IR pair per advance
// over a req/ack memory port and hands the branch unit a one-cycle advance strobe.
module ifu_pair_fetch
   import kl_fetch_pkg::*;
#(
   parameter logic [8:0]  RESET_PC = 9'h000,
   parameter logic [15:0] NOP_IR   = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_in,
   input  logic [8:0]  pc_next_in,
   output logic [8:0]  pc_out,
   output logic        fetch_next_out,
   output logic [15:0] p0_ir_out,
   output logic [15:0] p1_ir_out,
   output logic        ir_valid_out,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata
);

   // Pair fetches are always even-aligned, so bit0 of any PC is dropped.
   localparam logic [8:0] RESET_PC_EVEN = RESET_PC & 9'h1FE;

   logic [1:0]   state_q_s;
   fetch_state_t state_r;
   fetch_state_t state_nxt_s;
   logic [8:0]   pc_r;
   logic [8:0]   pc_load_s;
   logic         valid_r;
   logic         valid_nxt_s;
   logic         req_r;
   logic         req_nxt_s;
   logic         fetch_s;
   logic         load_s;
   logic         clr_s;
   ir_pair_t     rdata_pair_s;
   ir_pair_t     pair_r;

   assign state_r      = fetch_state_t'(state_q_s);
   assign pc_load_s    = pc_next_in & 9'h1FE;
   assign rdata_pair_s = ir_pair_t'(imem_rdata);

   // Sequencer: BOOT idles one cycle, WAIT holds the request until ack, VALID holds the pair.
   always_comb begin
      state_nxt_s = state_r;
      fetch_s     = 1'b0;
      load_s      = 1'b0;
      clr_s       = 1'b0;
      if (rst) begin
         state_nxt_s = BOOT;
      end else begin
         case (state_r)
            BOOT: begin
               state_nxt_s = WAIT;
            end
            WAIT: begin
               if (imem_ack) begin
                  load_s      = 1'b1;
                  state_nxt_s = VALID;
               end else begin
                  state_nxt_s = WAIT;
               end
            end
            VALID: begin
               if (!stall_in) begin
                  fetch_s     = 1'b1;
                  clr_s       = 1'b1;
                  state_nxt_s = WAIT;
               end else begin
                  state_nxt_s = VALID;
               end
            end
            default: begin
               state_nxt_s = BOOT;
            end
         endcase
      end
   end

   // Request and valid flags are registered copies of the next-state decode.
   assign valid_nxt_s = (state_nxt_s == VALID);
   assign req_nxt_s   = (state_nxt_s == WAIT);

   vDFF #(
      .WIDTH   (2),
      .RST_VAL (BOOT)
   ) u_state_reg (
      .clk (clk),
      .rst (rst),
      .d   (state_nxt_s),
      .q   (state_q_s)
   );

   vDFF_en #(
      .WIDTH   (9),
      .RST_VAL (RESET_PC_EVEN)
   ) u_pc_reg (
      .clk (clk),
      .rst (rst),
      .en  (fetch_s),
      .d   (pc_load_s),
      .q   (pc_r)
   );

   vDFF #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_valid_reg (
      .clk (clk),
      .rst (rst),
      .d   (valid_nxt_s),
      .q   (valid_r)
   );

   vDFF #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_req_reg (
      .clk (clk),
      .rst (rst),
      .d   (req_nxt_s),
      .q   (req_r)
   );

   ifu_pair_latch #(
      .NOP_IR (NOP_IR)
   ) u_pair_latch (
      .clk  (clk),
      .rst  (rst),
      .load (load_s),
      .clr  (clr_s),
      .d    (rdata_pair_s),
      .q    (pair_r)
   );

   assign pc_out         = pc_r;
   assign imem_addr      = pc_r[8:1];
   assign imem_req       = req_r;
   assign ir_valid_out   = valid_r;
   assign p0_ir_out      = pair_r.p0;
   assign p1_ir_out      = pair_r.p1;
   assign fetch_next_out = fetch_s;

endmodule

// File: tb/tb_ifu_pair_fetch.sv
// Self-checking bench for ifu_pair_fetch: reset, directed vector table, reset-in-WAIT
// sequence and randomized advances against a transaction-level memory model.
module tb_ifu_pair_fetch;

   localparam logic [15:0] NOP = 16'h0000;

   logic        clk;
   logic        rst;
   logic        stall_in;
   logic [8:0]  pc_next_in;
   logic [8:0]  pc_out;
   logic        fetch_next_out;
   logic [15:0] p0_ir_out;
   logic [15:0] p1_ir_out;
   logic        ir_valid_out;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic [31:0] mem [0:255];
   int          mem_delay;
   int          wcnt;
   logic        spur_ack;
   int          n_cmp;
   int          n_bad;

   logic [8:0]  cur_pc;
   logic [15:0] cur_p0;
   logic [15:0] cur_p1;

   typedef struct {
      logic [8:0]  pcn;
      int          dly;
      int          nstall;
      logic [7:0]  addr;
      logic [8:0]  pc;
      logic [15:0] p0;
      logic [15:0] p1;
   } vec_t;

   vec_t vt [6];

   ifu_pair_fetch #(
      .RESET_PC (9'h000),
      .NOP_IR   (16'h0000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_in       (stall_in),
      .pc_next_in     (pc_next_in),
      .pc_out         (pc_out),
      .fetch_next_out (fetch_next_out),
      .p0_ir_out      (p0_ir_out),
      .p1_ir_out      (p1_ir_out),
      .ir_valid_out   (ir_valid_out),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: acks after mem_delay request cycles; may pulse junk acks while idle.
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      wcnt       = 0;
      forever begin
         @(negedge clk);
         if (imem_req === 1'b1) begin
            if (wcnt >= mem_delay) begin
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr];
               wcnt       = 0;
            end else begin
               imem_ack   = 1'b0;
               imem_rdata = 32'hDEAD_DEAD;
               wcnt       = wcnt + 1;
            end
         end else begin
            imem_ack   = spur_ack;
            imem_rdata = $urandom;
            wcnt       = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // From VALID with stall_in=1: stall nstall cycles, advance, wait for the new pair.
   task automatic do_advance(input logic [8:0] pcn, input int dly, input int nstall,
                             input logic [7:0] e_addr, input logic [8:0] e_pc,
                             input logic [15:0] e_p0, input logic [15:0] e_p1);
      bit got;
      mem_delay  = dly;
      pc_next_in = pcn;
      spur_ack   = 1'b1;
      for (int i = 0; i < nstall; i++) begin
         @(negedge clk);
         #1;
         chk("stall_fetch", 32'(fetch_next_out), 32'd0);
         chk("stall_req",   32'(imem_req),       32'd0);
         chk("stall_valid", 32'(ir_valid_out),   32'd1);
         chk("stall_pc",    32'(pc_out),         32'(cur_pc));
         chk("stall_p0",    32'(p0_ir_out),      32'(cur_p0));
         chk("stall_p1",    32'(p1_ir_out),      32'(cur_p1));
      end
      @(negedge clk);
      spur_ack = 1'b0;
      stall_in = 1'b0;
      #1;
      chk("fetch_strobe", 32'(fetch_next_out), 32'd1);
      got = 1'b0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(negedge clk);
         if (n == 1) pc_next_in = 9'($urandom);
         if (ir_valid_out === 1'b1) begin
            stall_in = 1'b1;
            got      = 1'b1;
            #1;
            chk("latency",  32'(n),         32'(dly + 2));
            chk("pair_pc",  32'(pc_out),    32'(e_pc));
            chk("pair_p0",  32'(p0_ir_out), 32'(e_p0));
            chk("pair_p1",  32'(p1_ir_out), 32'(e_p1));
            chk("pair_req", 32'(imem_req),  32'd0);
         end else begin
            #1;
            chk("wait_req",   32'(imem_req),       32'd1);
            chk("wait_addr",  32'(imem_addr),      32'(e_addr));
            chk("wait_pc",    32'(pc_out),         32'(e_pc));
            chk("wait_p0",    32'(p0_ir_out),      32'(NOP));
            chk("wait_p1",    32'(p1_ir_out),      32'(NOP));
            chk("wait_fetch", 32'(fetch_next_out), 32'd0);
         end
      end
      if (!got) begin
         n_cmp    = n_cmp + 1;
         n_bad    = n_bad + 1;
         stall_in = 1'b1;
         $display("FAIL pair_timeout: valid never rose, expected pc %h", e_pc);
      end
      cur_pc = e_pc;
      cur_p0 = e_p0;
      cur_p1 = e_p1;
   endtask

   initial begin
      logic [8:0] rpc;
      logic [7:0] raddr;
      int         rdly;
      int         rst_cnt;

      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = {8'hA5, 8'(i), 8'h5A, ~8'(i)};
      end
      mem[0] = 32'hBEEF_1234;

      vt[0] = '{9'h023, 0, 5, 8'h11, 9'h022, 16'h5AEE, 16'hA511};
      vt[1] = '{9'h1FE, 4, 2, 8'hFF, 9'h1FE, 16'h5A00, 16'hA5FF};
      vt[2] = '{9'h000, 0, 0, 8'h00, 9'h000, 16'h1234, 16'hBEEF};
      vt[3] = '{9'h0A5, 1, 1, 8'h52, 9'h0A4, 16'h5AAD, 16'hA552};
      vt[4] = '{9'h101, 2, 0, 8'h80, 9'h100, 16'h5A7F, 16'hA580};
      vt[5] = '{9'h0FF, 3, 3, 8'h7F, 9'h0FE, 16'h5A80, 16'hA57F};

      // Reset state
      rst        = 1'b1;
      stall_in   = 1'b0;
      pc_next_in = 9'h0;
      spur_ack   = 1'b0;
      mem_delay  = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pc",    32'(pc_out),         32'd0);
      chk("rst_valid", 32'(ir_valid_out),   32'd0);
      chk("rst_req",   32'(imem_req),       32'd0);
      chk("rst_fetch", 32'(fetch_next_out), 32'd0);
      chk("rst_p0",    32'(p0_ir_out),      32'(NOP));
      chk("rst_p1",    32'(p1_ir_out),      32'(NOP));

      // First fetch after reset release: BOOT, WAIT (acked), then valid
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("boot_req",   32'(imem_req),     32'd0);
      chk("boot_valid", 32'(ir_valid_out), 32'd0);
      @(negedge clk);
      #1;
      chk("boot_wait_req",   32'(imem_req),       32'd1);
      chk("boot_wait_addr",  32'(imem_addr),      32'd0);
      chk("boot_wait_valid", 32'(ir_valid_out),   32'd0);
      chk("boot_wait_fetch", 32'(fetch_next_out), 32'd0);
      @(negedge clk);
      stall_in = 1'b1;
      #1;
      chk("first_valid", 32'(ir_valid_out), 32'd1);
      chk("first_pc",    32'(pc_out),       32'd0);
      chk("first_p0",    32'(p0_ir_out),    32'h1234);
      chk("first_p1",    32'(p1_ir_out),    32'hBEEF);
      cur_pc = 9'h000;
      cur_p0 = 16'h1234;
      cur_p1 = 16'hBEEF;

      // Directed vector table
      for (int v = 0; v < 6; v++) begin
         do_advance(vt[v].pcn, vt[v].dly, vt[v].nstall, vt[v].addr, vt[v].pc, vt[v].p0, vt[v].p1);
      end

      // Reset while WAIT with an ack arriving in the same cycle
      mem_delay  = 0;
      pc_next_in = 9'h044;
      @(negedge clk);
      stall_in = 1'b0;
      #1;
      chk("rw_fetch", 32'(fetch_next_out), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rw_req", 32'(imem_req), 32'd1);
      @(negedge clk);
      #1;
      chk("rw_valid", 32'(ir_valid_out),   32'd0);
      chk("rw_req0",  32'(imem_req),       32'd0);
      chk("rw_pc",    32'(pc_out),         32'd0);
      chk("rw_p0",    32'(p0_ir_out),      32'(NOP));
      chk("rw_p1",    32'(p1_ir_out),      32'(NOP));
      chk("rw_fetch0", 32'(fetch_next_out), 32'd0);
      rst_cnt = 0;
      rst = 1'b0;
      while (ir_valid_out !== 1'b1 && rst_cnt < 20) begin
         @(negedge clk);
         rst_cnt = rst_cnt + 1;
      end
      stall_in = 1'b1;
      #1;
      chk("rw_recover_cycles", 32'(rst_cnt),   32'd2);
      chk("rw_recover_p0",     32'(p0_ir_out), 32'h1234);
      chk("rw_recover_p1",     32'(p1_ir_out), 32'hBEEF);
      cur_pc = 9'h000;
      cur_p0 = 16'h1234;
      cur_p1 = 16'hBEEF;

      // Randomized advances against the memory model
      for (int i = 0; i < 256; i++) begin
         mem[i] = $urandom;
      end
      cur_p0 = mem[0][15:0];
      cur_p1 = mem[0][31:16];
      cur_pc = 9'h000;
      // Re-fetch address 0 so the held pair matches the refreshed memory image.
      do_advance(9'h001, 0, 0, 8'h00, 9'h000, mem[0][15:0], mem[0][31:16]);
      for (int k = 0; k < 40; k++) begin
         rpc   = 9'($urandom_range(0, 511));
         raddr = rpc[8:1];
         rdly  = $urandom_range(0, 3);
         do_advance(rpc, rdly, $urandom_range(0, 3), raddr, {raddr, 1'b0},
                    mem[raddr][15:0], mem[raddr][31:16]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
